// File: rtl/gf_pkg.sv
// Shared types for the GF(2^163) multiplier arbiter: field element width and arbiter FSM states.
package gf_pkg;

   localparam int NUM_BITS_DEF = 163;
   localparam int GF_W         = NUM_BITS_DEF + 1;

   typedef logic [GF_W-1:0] gf_elem_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

endpackage

// File: rtl/gf_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping N-1 -> 0.
module gf_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] rr_ptr,
   output logic [N-1:0]         gnt_vec,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] cand;

   // NOTE: every output gets a default before the loop so no path leaves a value held (no latch).
   // NOTE: blocking assignments here: cand is a loop-carried temporary, not state.
   always_comb begin
      gnt_vec = '0;
      idx     = '0;
      any     = 1'b0;
      cand    = rr_ptr;
      for (int k = 0; k < N; k++) begin
         if (!any && req[cand]) begin
            gnt_vec[cand] = 1'b1;
            idx           = cand;
            any           = 1'b1;
         end
         cand = (cand == PW'(N - 1)) ? '0 : cand + PW'(1);
      end
   end

endmodule

// File: rtl/gf_mult_arbiter.sv
// Round-robin sharing of one gf_Mult multiplier between NUM_REQ sequencers, with a watchdog
// that turns a hung multiplication into an error response instead of a deadlock.
module gf_mult_arbiter
   import gf_pkg::*;
#(
   parameter int NUM_BITS = NUM_BITS_DEF,
   parameter int NUM_REQ  = 4,
   parameter int TIMEOUT  = 200
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*(NUM_BITS+1)-1:0] req_a,
   input  logic [NUM_REQ*(NUM_BITS+1)-1:0] req_b,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [NUM_BITS:0]               rsp_product,
   output logic                            rsp_err,
   output logic                            busy,
   output logic                            mult_start,
   output logic [NUM_BITS:0]               mult_a,
   output logic [NUM_BITS:0]               mult_b,
   input  logic [NUM_BITS:0]               mult_product,
   input  logic                            mult_done
);

   localparam int W     = NUM_BITS + 1;
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, owner_q, pick_idx;
   logic [NUM_REQ-1:0] pick_vec;
   logic              pick_any;
   logic [W-1:0]      sel_a, sel_b, result_q;
   logic              err_q;
   logic [WD_W-1:0]   wd_q;
   logic              wd_expired;

   gf_rr_pick #(.N(NUM_REQ)) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .gnt_vec (pick_vec),
      .idx     (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            sel_a = req_a[i*W +: W];
            sel_b = req_b[i*W +: W];
         end
      end
   end

   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (mult_done || wd_expired) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: the wide operand/result registers are reset too, so buses read 0 after any abort.
   // NOTE: non-blocking everywhere below: each flop samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rr_ptr_q <= '0;
         owner_q  <= '0;
         mult_a   <= '0;
         mult_b   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         wd_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  mult_a  <= sel_a;
                  mult_b  <= sel_b;
                  owner_q <= pick_idx;
               end
            end
            ISSUE: wd_q <= '0;
            WAIT: begin
               if (wd_q != WD_W'(TIMEOUT)) wd_q <= wd_q + WD_W'(1);
               // A done arriving on the expiry cycle still counts as success.
               if (mult_done) begin
                  result_q <= mult_product;
                  err_q    <= 1'b0;
               end else if (wd_expired) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end
            end
            RESP: begin
               rr_ptr_q <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = (state_q == RESP) && (owner_q == IDX_W'(i));
      end
   end

   assign gnt         = (state_q == IDLE) ? pick_vec : '0;
   assign mult_start  = (state_q == ISSUE);
   assign busy        = (state_q != IDLE);
   assign rsp_product = result_q;
   assign rsp_err     = (state_q == RESP) && err_q;

endmodule
